sdram_arbiter: RTL

Round-robin scheduler that shares the single `sdram_controller` between `NUM_REQ` requesters. It accepts one read or write request at a time and drives the controller's start strobes and row/column address. It then waits for the controller's data-valid completion and returns a per-requester done pulse. It sits between the user logic in `tt_um_gmejiamtz` and the `sdram_controller` instance.

---
 rtl/sdram_arb_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 30 +++
 rtl/sdram_arbiter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types and default widths for the SDRAM request arbiter.
// Optional completion timeout is enabled by defining SDRAM_ARB_TIMEOUT_EN.
package sdram_arb_pkg;

  localparam int SDRAM_ROW_W = 13;
  localparam int SDRAM_COL_W = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  // One captured request at the controller's native address widths.
  typedef struct packed {
    logic                   we;
    logic [SDRAM_ROW_W-1:0] row;
    logic [SDRAM_COL_W-1:0] col;
  } sdram_cmd_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after 'last' (with
// wrap-around) that has a pending request, plus a found flag.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic [IDX_W-1:0]   idx_o,
  output logic               found_o
);

  // Search last+1, last+2, ... and keep the first hit.
  always_comb begin
    int cand;
    // NOTE: every output gets a default before the search so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    idx_o   = '0;
    found_o = 1'b0;
    cand    = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = (int'(last_i) + off) % NUM_REQ;
      if (!found_o && req_valid_i[cand]) begin
        found_o = 1'b1;
        idx_o   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin scheduler sharing one sdram_controller between NUM_REQ
// requesters: one outstanding read or write at a time, completion reported
// as a per-requester done pulse.
// Define SDRAM_ARB_TIMEOUT_EN to add a completion timeout (req_err pulse).
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ROW_W   = SDRAM_ROW_W,
  parameter int COL_W   = SDRAM_COL_W,
  parameter int TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_we,
  input  logic [NUM_REQ*ROW_W-1:0]   req_row,
  input  logic [NUM_REQ*COL_W-1:0]   req_col,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         req_done,
  output logic [NUM_REQ-1:0]         req_err,
  output logic                       ctl_read_start,
  output logic                       ctl_write_start,
  output logic [ROW_W-1:0]           ctl_row,
  output logic [COL_W-1:0]           ctl_col,
  input  logic                       ctl_read_valid,
  input  logic                       ctl_write_valid,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int IDX_W = $clog2(NUM_REQ);

  // Captured request at this instance's widths.
  typedef struct packed {
    logic             we;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
  } cmd_t;

  arb_state_e         state_q;
  cmd_t               cmd_q;
  logic [IDX_W-1:0]   grant_q;
  logic [IDX_W-1:0]   last_q;
  logic [NUM_REQ-1:0] ready_q;
  logic [NUM_REQ-1:0] done_q;
  logic               rd_start_q;
  logic               wr_start_q;
  logic [IDX_W-1:0]   pick;
  logic               found;
  logic               match;

`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam int CNT_RAW = $clog2(TIMEOUT + 1);
  localparam int CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 16) ? 16 : CNT_RAW);
  logic [CNT_W-1:0]   cnt_q;
  logic [NUM_REQ-1:0] err_q;
`endif

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_valid_i (req_valid),
    .last_i      (last_q),
    .idx_o       (pick),
    .found_o     (found)
  );

  // Only the valid that matches the outstanding command's direction counts.
  assign match = cmd_q.we ? ctl_write_valid : ctl_read_valid;

  // Arbitration FSM with registered strobes, pulses and captured command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cmd_q      <= '0;
      grant_q    <= '0;
      last_q     <= IDX_W'(NUM_REQ - 1);
      ready_q    <= '0;
      done_q     <= '0;
      rd_start_q <= 1'b0;
      wr_start_q <= 1'b0;
`ifdef SDRAM_ARB_TIMEOUT_EN
      cnt_q      <= '0;
      err_q      <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout; the pulse defaults below
      // are overridden by later assignments in the same edge.
      ready_q    <= '0;
      done_q     <= '0;
      rd_start_q <= 1'b0;
      wr_start_q <= 1'b0;
`ifdef SDRAM_ARB_TIMEOUT_EN
      err_q      <= '0;
`endif
      unique case (state_q)
        IDLE: begin
          if (found) begin
            grant_q       <= pick;
            cmd_q.we      <= req_we[pick];
            cmd_q.row     <= req_row[int'(pick)*ROW_W +: ROW_W];
            cmd_q.col     <= req_col[int'(pick)*COL_W +: COL_W];
            ready_q[pick] <= 1'b1;
            rd_start_q    <= ~req_we[pick];
            wr_start_q    <= req_we[pick];
            state_q       <= ISSUE;
`ifdef SDRAM_ARB_TIMEOUT_EN
            cnt_q         <= '0;
`endif
          end
        end
        ISSUE: begin
          last_q <= grant_q;
          if (match) begin
            done_q[grant_q] <= 1'b1;
            state_q         <= IDLE;
          end else begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (match) begin
            done_q[grant_q] <= 1'b1;
            state_q         <= IDLE;
          end
`ifdef SDRAM_ARB_TIMEOUT_EN
          else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            err_q[grant_q] <= 1'b1;
            state_q        <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready       = ready_q;
  assign req_done        = done_q;
  assign ctl_read_start  = rd_start_q;
  assign ctl_write_start = wr_start_q;
  assign ctl_row         = cmd_q.row;
  assign ctl_col         = cmd_q.col;
  assign busy            = (state_q != IDLE);
  assign grant_id        = grant_q;
`ifdef SDRAM_ARB_TIMEOUT_EN
  assign req_err         = err_q;
`else
  assign req_err         = '0;
`endif

endmodule
